// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, load_op encodings and bus layouts.
// The MS_LWLR_EN build option is consumed by ms_load_align and mem_stage.
package mem_stage_pkg;

   localparam int unsigned ES_TO_MS_BUS_WD = 123;
   localparam int unsigned MS_TO_WS_BUS_WD = 85;
   localparam int unsigned STALL_BUS_WD    = 10;
   localparam int unsigned FORWARD_BUS_WD  = 33;

   typedef enum logic [2:0] {
      LOAD_LW     = 3'd0,
      LOAD_LB     = 3'd1,
      LOAD_LBU    = 3'd2,
      LOAD_LH     = 3'd3,
      LOAD_LHU    = 3'd4,
      LOAD_LWL    = 3'd5,
      LOAD_LWR    = 3'd6,
      LOAD_LW_ALT = 3'd7
   } load_op_e;

   typedef struct packed {
      logic        exc_sys;
      logic        eret;
      logic        cp0_wen;
      logic        res_from_cp0;
      logic [7:0]  cp0_addr;
      load_op_e    load_op;
      logic        mem_req;
      logic [1:0]  ea_lo;
      logic [31:0] rt_value;
      logic [3:0]  gr_we;
      logic [4:0]  dest;
      logic [31:0] alu_result;
      logic [31:0] pc;
   } es_to_ms_t;

   typedef struct packed {
      logic        exc_sys;
      logic        eret;
      logic        cp0_wen;
      logic        res_from_cp0;
      logic [7:0]  cp0_addr;
      logic [3:0]  gr_we;
      logic [4:0]  dest;
      logic [31:0] final_result;
      logic [31:0] pc;
   } ms_to_ws_t;

   // Widen a byte (half=0, data[7:0]) or halfword (half=1) to 32 bits.
   function automatic logic [31:0] extend_load(input logic [15:0] data, input logic half,
                                               input logic is_signed);
      logic fill;
      fill = is_signed && (half ? data[15] : data[7]);
      return half ? {{16{fill}}, data} : {{24{fill}}, data[7:0]};
   endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// ms_load_align: combinational load-data extraction and extension for the MEM stage.
// With MS_LWLR_EN defined, LWL/LWR merge with rt_value and narrow gr_we per byte.
module ms_load_align
   import mem_stage_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  ea_lo,
   input  load_op_e    load_op,
   input  logic [31:0] rt_value,
   input  logic [3:0]  gr_we_in,
   output logic [31:0] result,
   output logic [3:0]  gr_we_out
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = rdata[{ea_lo, 3'b000} +: 8];
   assign half_sel = ea_lo[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      result    = rdata;
      gr_we_out = gr_we_in;
      case (load_op)
         LOAD_LB:  result = extend_load({8'h00, byte_sel}, 1'b0, 1'b1);
         LOAD_LBU: result = extend_load({8'h00, byte_sel}, 1'b0, 1'b0);
         LOAD_LH:  result = extend_load(half_sel, 1'b1, 1'b1);
         LOAD_LHU: result = extend_load(half_sel, 1'b1, 1'b0);
`ifdef MS_LWLR_EN
         LOAD_LWL: begin
            case (ea_lo)
               2'd0:    begin result = {rdata[7:0],  rt_value[23:0]}; gr_we_out = 4'b1000; end
               2'd1:    begin result = {rdata[15:0], rt_value[15:0]}; gr_we_out = 4'b1100; end
               2'd2:    begin result = {rdata[23:0], rt_value[7:0]};  gr_we_out = 4'b1110; end
               default: begin result = rdata;                         gr_we_out = 4'b1111; end
            endcase
         end
         LOAD_LWR: begin
            case (ea_lo)
               2'd0:    begin result = rdata;                           gr_we_out = 4'b1111; end
               2'd1:    begin result = {rt_value[31:24], rdata[31:8]};  gr_we_out = 4'b0111; end
               2'd2:    begin result = {rt_value[31:16], rdata[31:16]}; gr_we_out = 4'b0011; end
               default: begin result = {rt_value[31:8],  rdata[31:24]}; gr_we_out = 4'b0001; end
            endcase
         end
`endif
         default: ;
      endcase
   end

`ifndef MS_LWLR_EN
   logic unused_rt;
   assign unused_rt = ^rt_value;
`endif

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage between EX and WB; waits for data-SRAM responses,
// buffers early responses, drops responses of flushed requests. Option: MS_LWLR_EN.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       ws_allowin,
   output logic                       ms_allowin,
   input  logic                       es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   input  logic                       es_mem_inflight,
   input  logic                       data_sram_data_ok,
   input  logic [31:0]                data_sram_rdata,
   output logic                       ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
   output logic [STALL_BUS_WD-1:0]    stall_ms_bus,
   output logic [FORWARD_BUS_WD-1:0]  forward_ms_bus
);

   es_to_ms_t   ms_r;
   ms_to_ws_t   ws_bus;
   logic        ms_valid;
   logic        resp_buf_valid;
   logic [31:0] rdata_buf;
   logic [1:0]  discard_cnt;
   logic [2:0]  discard_sum;
   logic        data_ok_live;
   logic        ms_ready_go;
   logic        is_load;
   logic [31:0] load_rdata;
   logic [31:0] load_result;
   logic [3:0]  load_we;
   logic [31:0] final_result;

   // A response only belongs to the current request once all stale ones are drained.
   assign data_ok_live   = data_sram_data_ok && (discard_cnt == 2'd0);
   assign ms_ready_go    = !ms_r.mem_req || resp_buf_valid || data_ok_live;
   assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
   assign ms_to_ws_valid = ms_valid && ms_ready_go;

   assign is_load    = ms_r.mem_req && (|ms_r.gr_we);
   assign load_rdata = resp_buf_valid ? rdata_buf : data_sram_rdata;

   ms_load_align u_load_align (
      .rdata     (load_rdata),
      .ea_lo     (ms_r.ea_lo),
      .load_op   (ms_r.load_op),
      .rt_value  (ms_r.rt_value),
      .gr_we_in  (ms_r.gr_we),
      .result    (load_result),
      .gr_we_out (load_we)
   );

   assign final_result = is_load ? load_result : ms_r.alu_result;

   always_comb begin
      ws_bus              = '0;
      ws_bus.exc_sys      = ms_r.exc_sys;
      ws_bus.eret         = ms_r.eret;
      ws_bus.cp0_wen      = ms_r.cp0_wen;
      ws_bus.res_from_cp0 = ms_r.res_from_cp0;
      ws_bus.cp0_addr     = ms_r.cp0_addr;
      ws_bus.gr_we        = is_load ? load_we : ms_r.gr_we;
      ws_bus.dest         = ms_r.dest;
      ws_bus.final_result = final_result;
      ws_bus.pc           = ms_r.pc;
   end

   assign ms_to_ws_bus   = ws_bus;
   assign stall_ms_bus   = {ms_valid && (|ms_r.gr_we), {4{ms_valid}} & ms_r.gr_we, ms_r.dest};
   assign forward_ms_bus = {ms_to_ws_valid, final_result};

   // Flush adds our own unanswered request plus any EX-side one; stale responses drain one each.
   always_comb begin
      discard_sum = {1'b0, discard_cnt};
      if (flush) begin
         discard_sum = discard_sum
                     + {2'b00, ms_valid && ms_r.mem_req && !resp_buf_valid && !data_ok_live}
                     + {2'b00, es_mem_inflight};
      end
      if (data_sram_data_ok && (discard_cnt != 2'd0)) begin
         discard_sum = discard_sum - 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ms_valid       <= 1'b0;
         resp_buf_valid <= 1'b0;
         rdata_buf      <= '0;
         discard_cnt    <= '0;
         ms_r           <= '0;
      end else begin
         discard_cnt <= (discard_sum > 3'd3) ? 2'd3 : discard_sum[1:0];
         if (flush) begin
            ms_valid       <= 1'b0;
            resp_buf_valid <= 1'b0;
         end else begin
            if (ms_allowin) begin
               ms_valid <= es_to_ms_valid;
            end
            if (es_to_ms_valid && ms_allowin) begin
               ms_r <= es_to_ms_t'(es_to_ms_bus);
            end
            if (data_ok_live && ms_valid && ms_r.mem_req && !ws_allowin) begin
               resp_buf_valid <= 1'b1;
               rdata_buf      <= data_sram_rdata;
            end else if (ms_to_ws_valid && ws_allowin) begin
               resp_buf_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scenarios plus randomized traffic against a transaction-level
// model of the MEM stage. Expectations follow MS_LWLR_EN when it is defined.
module tb_mem_stage;

   logic         clk = 1'b0;
   logic         reset;
   logic         flush;
   logic         ws_allowin;
   logic         ms_allowin;
   logic         es_to_ms_valid;
   logic [122:0] es_to_ms_bus;
   logic         es_mem_inflight;
   logic         data_sram_data_ok;
   logic [31:0]  data_sram_rdata;
   logic         ms_to_ws_valid;
   logic [84:0]  ms_to_ws_bus;
   logic [9:0]   stall_ms_bus;
   logic [32:0]  forward_ms_bus;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk               (clk),
      .reset             (reset),
      .flush             (flush),
      .ws_allowin        (ws_allowin),
      .ms_allowin        (ms_allowin),
      .es_to_ms_valid    (es_to_ms_valid),
      .es_to_ms_bus      (es_to_ms_bus),
      .es_mem_inflight   (es_mem_inflight),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata),
      .ms_to_ws_valid    (ms_to_ws_valid),
      .ms_to_ws_bus      (ms_to_ws_bus),
      .stall_ms_bus      (stall_ms_bus),
      .forward_ms_bus    (forward_ms_bus)
   );

   task automatic check(input string tag, input logic [84:0] got, input logic [84:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic ev, input logic [122:0] bus, input logic ok,
                        input logic [31:0] rd, input logic wa, input logic fl, input logic inf);
      es_to_ms_valid    = ev;
      es_to_ms_bus      = bus;
      data_sram_data_ok = ok;
      data_sram_rdata   = rd;
      ws_allowin        = wa;
      flush             = fl;
      es_mem_inflight   = inf;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [122:0] mk_op(input logic [2:0] lop, input logic mreq,
      input logic [1:0] ea, input logic [31:0] rt, input logic [3:0] we, input logic [4:0] dest,
      input logic [31:0] alu, input logic [31:0] pc);
      return {12'h000, lop, mreq, ea, rt, we, dest, alu, pc};
   endfunction

   function automatic logic [122:0] rand_op();
      logic [122:0] op;
      int unsigned  kind;
      kind = $urandom_range(2);   // 0 ALU, 1 load, 2 store
      op = mk_op(3'($urandom_range(7)), kind != 0, 2'($urandom_range(3)), $urandom,
                 (kind == 1) ? 4'hF : (kind == 2) ? 4'h0 : 4'($urandom_range(15)),
                 5'($urandom_range(31)), $urandom, $urandom);
      op[122:111] = 12'($urandom);
      return op;
   endfunction

   // Reference: load value from the architectural rules, using plain shifts and arithmetic.
   function automatic logic [31:0] model_load(input logic [122:0] op, input logic [31:0] rd);
      logic [2:0]  lop;
      logic [1:0]  ea;
      logic [31:0] rt;
      int unsigned b, h;
      lop = op[110:108];
      ea  = op[106:105];
      rt  = op[104:73];
      b   = (rd >> (8 * ea)) & 32'hFF;
      h   = ea[1] ? (rd >> 16) : (rd & 32'hFFFF);
      case (lop)
         3'd1: return (b >= 128) ? b - 256 : b;
         3'd2: return b;
         3'd3: return (h >= 32768) ? h - 65536 : h;
         3'd4: return h;
`ifdef MS_LWLR_EN
         3'd5: return (rd << (8 * (3 - ea))) | (rt & ((32'd1 << (8 * (3 - ea))) - 1));
         3'd6: return (rd >> (8 * ea)) | (rt & ~(32'hFFFF_FFFF >> (8 * ea)));
`endif
         default: return rd;
      endcase
   endfunction

   function automatic logic [3:0] model_we(input logic [122:0] op);
      logic [3:0] m;
      m = 4'hF;
`ifdef MS_LWLR_EN
      if (op[110:108] == 3'd5) return m << (3 - op[106:105]);
      if (op[110:108] == 3'd6) return m >> op[106:105];
`endif
      return op[72:69];
   endfunction

   function automatic logic [84:0] exp_ws(input logic [122:0] op, input logic [31:0] rd);
      logic        load;
      logic [31:0] res;
      logic [3:0]  we;
      load = op[107] && (op[72:69] != 4'h0);
      res  = load ? model_load(op, rd) : op[63:32];
      we   = load ? model_we(op) : op[72:69];
      return {op[122:111], we, op[68:64], res, op[31:0]};
   endfunction

   function automatic logic [9:0] exp_stall(input logic [122:0] op, input logic v);
      return {v && (op[72:69] != 4'h0), v ? op[72:69] : 4'h0, op[68:64]};
   endfunction

   initial begin
      logic [122:0] op, cur, nxt;
      logic [84:0]  w;
      logic [31:0]  cur_rd;
      logic         mvalid, got, wa, ok, ev, vexp, aexp;
      int unsigned  dly;

      drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
      check("rst_valid", ms_to_ws_valid, 1'b0);
      check("rst_allowin", ms_allowin, 1'b1);
      check("rst_stall", stall_ms_bus, 10'h0);
      check("rst_fwd", forward_ms_bus, 33'h0);
      check("rst_wsbus", ms_to_ws_bus, 85'h0);

      // LB, ea_lo=3, response in the first MEM cycle
      tick();
      drive(1'b1, mk_op(3'd1, 1'b1, 2'd3, 32'h0, 4'hF, 5'd2, 32'h5555, 32'h100), 1'b0, '0, 1'b1, 1'b0, 1'b0);
      #1;
      check("lb_allowin", ms_allowin, 1'b1);
      tick();
      drive(1'b0, '0, 1'b1, 32'h80112233, 1'b1, 1'b0, 1'b0);
      #1;
      check("lb_valid", ms_to_ws_valid, 1'b1);
      check("lb_result", ms_to_ws_bus[63:32], 32'hFFFFFF80);
      check("lb_fwd", forward_ms_bus, {1'b1, 32'hFFFFFF80});
      tick();
      drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
      #1;
      check("lb_drain", ms_to_ws_valid, 1'b0);

      // LHU, ea_lo=2, response three cycles late
      tick();
      drive(1'b1, mk_op(3'd4, 1'b1, 2'd2, 32'h0, 4'hF, 5'd7, 32'h0, 32'h104), 1'b0, '0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
         #1;
         check("lhu_wait_valid", ms_to_ws_valid, 1'b0);
         check("lhu_wait_busy", stall_ms_bus[9], 1'b1);
         check("lhu_wait_fwdv", forward_ms_bus[32], 1'b0);
         check("lhu_wait_allowin", ms_allowin, 1'b0);
      end
      tick();
      drive(1'b0, '0, 1'b1, 32'h89AB1234, 1'b1, 1'b0, 1'b0);
      #1;
      check("lhu_valid", ms_to_ws_valid, 1'b1);
      check("lhu_result", ms_to_ws_bus[63:32], 32'h000089AB);

      // LW whose response arrives while WB is blocked
      tick();
      drive(1'b1, mk_op(3'd0, 1'b1, 2'd0, 32'h0, 4'hF, 5'd3, 32'h0, 32'h108), 1'b0, '0, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
      #1;
      check("buf_valid0", ms_to_ws_valid, 1'b1);
      check("buf_allowin0", ms_allowin, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      #1;
      check("buf_valid1", ms_to_ws_valid, 1'b1);
      check("buf_hold_result", ms_to_ws_bus[63:32], 32'hDEADBEEF);
      tick();
      drive(1'b0, '0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      #1;
      check("buf_release_result", ms_to_ws_bus[63:32], 32'hDEADBEEF);
      check("buf_release_allowin", ms_allowin, 1'b1);
      tick();
      drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
      #1;
      check("buf_drain", ms_to_ws_valid, 1'b0);

      // ALU op
      tick();
      drive(1'b1, mk_op(3'd0, 1'b0, 2'd0, 32'h0, 4'hF, 5'd5, 32'h1234, 32'h10C), 1'b0, '0, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
      #1;
      check("alu_fwd", forward_ms_bus, {1'b1, 32'h00001234});
      check("alu_stall", stall_ms_bus, {1'b1, 4'hF, 5'd5});

      // Flush with an outstanding LW and one more request in flight from EX
      tick();
      drive(1'b1, mk_op(3'd0, 1'b1, 2'd0, 32'h0, 4'hF, 5'd9, 32'h0, 32'h110), 1'b0, '0, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
      tick();
      drive(1'b1, mk_op(3'd0, 1'b1, 2'd0, 32'h0, 4'hF, 5'd10, 32'h0, 32'h114), 1'b0, '0, 1'b1, 1'b0, 1'b0);
      #1;
      check("fl_valid", ms_to_ws_valid, 1'b0);
      check("fl_allowin", ms_allowin, 1'b1);
      tick();
      drive(1'b0, '0, 1'b1, 32'h11111111, 1'b1, 1'b0, 1'b0);
      #1;
      check("fl_drop1", ms_to_ws_valid, 1'b0);
      tick();
      drive(1'b0, '0, 1'b1, 32'h22222222, 1'b1, 1'b0, 1'b0);
      #1;
      check("fl_drop2", ms_to_ws_valid, 1'b0);
      tick();
      drive(1'b0, '0, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0);
      #1;
      check("fl_pass_valid", ms_to_ws_valid, 1'b1);
      check("fl_pass_result", ms_to_ws_bus[63:32], 32'hCAFEF00D);
      check("fl_pass_dest", ms_to_ws_bus[68:64], 5'd10);

      // Reset in the middle of a load, then a fresh load must not be discarded
      tick();
      drive(1'b1, mk_op(3'd0, 1'b1, 2'd0, 32'h0, 4'hF, 5'd11, 32'h0, 32'h118), 1'b0, '0, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check("rmid_valid", ms_to_ws_valid, 1'b0);
      check("rmid_wsbus", ms_to_ws_bus, 85'h0);
      check("rmid_stall", stall_ms_bus, 10'h0);
      check("rmid_fwd", forward_ms_bus, 33'h0);
      check("rmid_allowin", ms_allowin, 1'b1);
      tick();
      drive(1'b1, mk_op(3'd0, 1'b1, 2'd0, 32'h0, 4'hF, 5'd12, 32'h0, 32'h11C), 1'b0, '0, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, 1'b1, 32'h13579BDF, 1'b1, 1'b0, 1'b0);
      #1;
      check("rmid_next_valid", ms_to_ws_valid, 1'b1);
      check("rmid_next_result", ms_to_ws_bus[63:32], 32'h13579BDF);

      // LWL / LWR, ea_lo=1
      tick();
      drive(1'b1, mk_op(3'd5, 1'b1, 2'd1, 32'h11223344, 4'hF, 5'd13, 32'h0, 32'h120), 1'b0, '0, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, 1'b1, 32'hAABBCCDD, 1'b1, 1'b0, 1'b0);
      #1;
`ifdef MS_LWLR_EN
      check("lwl_result", ms_to_ws_bus[63:32], 32'hCCDD3344);
      check("lwl_we", ms_to_ws_bus[72:69], 4'b1100);
`else
      check("lwl_result", ms_to_ws_bus[63:32], 32'hAABBCCDD);
      check("lwl_we", ms_to_ws_bus[72:69], 4'b1111);
`endif
      tick();
      drive(1'b1, mk_op(3'd6, 1'b1, 2'd1, 32'h11223344, 4'hF, 5'd14, 32'h0, 32'h124), 1'b0, '0, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, 1'b1, 32'hAABBCCDD, 1'b1, 1'b0, 1'b0);
      #1;
`ifdef MS_LWLR_EN
      check("lwr_result", ms_to_ws_bus[63:32], 32'h11AABBCC);
      check("lwr_we", ms_to_ws_bus[72:69], 4'b0111);
`else
      check("lwr_result", ms_to_ws_bus[63:32], 32'hAABBCCDD);
      check("lwr_we", ms_to_ws_bus[72:69], 4'b1111);
`endif

      // Randomized traffic: the model tracks one op in the stage and whether its response came
      tick();
      reset = 1'b1;
      drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
      tick();
      reset  = 1'b0;
      cur    = '0;
      cur_rd = '0;
      mvalid = 1'b0;
      got    = 1'b0;
      dly    = 0;
      nxt    = rand_op();
      repeat (3000) begin
         tick();
         wa = ($urandom_range(3) != 0);
         ok = mvalid && cur[107] && !got && (dly == 0);
         ev = ($urandom_range(9) < 7);
         drive(ev, nxt, ok, ok ? cur_rd : $urandom, wa, 1'b0, 1'b0);
         #1;
         vexp = mvalid && (!cur[107] || got || ok);
         aexp = !mvalid || (vexp && wa);
         check("rnd_valid", ms_to_ws_valid, vexp);
         check("rnd_allowin", ms_allowin, aexp);
         check("rnd_stall", stall_ms_bus, exp_stall(cur, mvalid));
         if (vexp) begin
            w = exp_ws(cur, cur_rd);
            check("rnd_wsbus", ms_to_ws_bus, w);
            check("rnd_fwd", forward_ms_bus, {1'b1, w[63:32]});
         end else begin
            check("rnd_fwd_valid", forward_ms_bus[32], 1'b0);
         end
         if (vexp && wa) begin
            mvalid = 1'b0;
         end else if (mvalid && ok) begin
            got = 1'b1;
         end else if (mvalid && cur[107] && !got && (dly > 0)) begin
            dly--;
         end
         if (ev && aexp) begin
            cur    = nxt;
            cur_rd = $urandom;
            mvalid = 1'b1;
            got    = 1'b0;
            dly    = $urandom_range(3);
            nxt    = rand_op();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
